// File: rtl/argmax_top2.sv
// Streaming signed top-2 argmax over a frame of NUM_CLASSES scores.
// Reports best/second score with indices and the unsigned margin between them.
module argmax_top2 #(
  parameter  int DATA_W      = 16,
  parameter  int NUM_CLASSES = 10,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] best_val,
  output logic [IDX_W-1:0]  second_idx,
  output logic [DATA_W-1:0] second_val,
  output logic [DATA_W:0]   margin,
  output logic              done,
  output logic              busy,
  output logic              stray_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(NUM_CLASSES - 1);

  state_t                    state_q, state_d;
  logic                      start_q;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  best_val_q, best_val_d;
  logic signed [DATA_W-1:0]  second_val_q, second_val_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          second_idx_q, second_idx_d;
  logic [DATA_W:0]           margin_q, margin_d;
  logic                      stray_q, stray_d;
  logic                      start_pulse;
  logic                      clear;
  logic signed [DATA_W-1:0]  x;

  always_comb begin
    start_pulse  = start & ~start_q;
    x            = $signed(in_data);
    clear        = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    second_val_d = second_val_q;
    second_idx_d = second_idx_q;
    stray_d      = stray_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d = S_ACCUM;
          clear   = 1'b1;
        end
      end
      S_ACCUM: begin
        if (start_pulse) begin
          clear = 1'b1;
        end else if (in_valid) begin
          if (x > best_val_q) begin
            second_val_d = best_val_q;
            second_idx_d = best_idx_q;
            best_val_d   = x;
            best_idx_d   = cnt_q;
          end else if (x > second_val_q) begin
            second_val_d = x;
            second_idx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      cnt_d        = '0;
      best_val_d   = MIN_VAL;
      second_val_d = MIN_VAL;
      best_idx_d   = '0;
      second_idx_d = '0;
      stray_d      = 1'b0;
    end

    // A beat offered while not accepting is recorded even on a start edge
    if (in_valid && state_q != S_ACCUM) stray_d = 1'b1;

    margin_d = {best_val_d[DATA_W-1], best_val_d}
             - {second_val_d[DATA_W-1], second_val_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      second_val_q <= '0;
      second_idx_q <= '0;
      margin_q     <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      cnt_q        <= cnt_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      second_val_q <= second_val_d;
      second_idx_q <= second_idx_d;
      margin_q     <= margin_d;
      stray_q      <= stray_d;
    end
  end

  assign in_ready   = (state_q == S_ACCUM);
  assign busy       = (state_q == S_ACCUM);
  assign done       = (state_q == S_DONE);
  assign best_idx   = best_idx_q;
  assign best_val   = best_val_q;
  assign second_idx = second_idx_q;
  assign second_val = second_val_q;
  assign margin     = margin_q;
  assign stray_err  = stray_q;

endmodule

// File: tb/tb_argmax_top2.sv
// Self-checking bench for argmax_top2: directed frames against a
// whole-frame reference model, checked on every done pulse.
module tb_argmax_top2;

  localparam int DW = 16;
  localparam int NC = 10;
  localparam int IW = $clog2(NC);

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] best_idx;
  logic [DW-1:0] best_val;
  logic [IW-1:0] second_idx;
  logic [DW-1:0] second_val;
  logic [DW:0]   margin;
  logic          done;
  logic          busy;
  logic          stray_err;

  argmax_top2 #(.DATA_W(DW), .NUM_CLASSES(NC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .best_idx(best_idx), .best_val(best_val),
    .second_idx(second_idx), .second_val(second_val),
    .margin(margin), .done(done), .busy(busy),
    .stray_err(stray_err)
  );

  typedef struct {
    int bi;
    int bv;
    int si;
    int sv;
    int mg;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -100;
  int   done_cnt = 0;
  int   frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Best is the lowest-index maximum; second is the lowest-index
  // maximum among the remaining classes.
  function automatic res_t model(input int s[NC]);
    res_t r;
    r.bi = 0;
    for (int i = 1; i < NC; i++)
      if (s[i] > s[r.bi]) r.bi = i;
    r.si = (r.bi == 0) ? 1 : 0;
    for (int i = 0; i < NC; i++)
      if (i != r.bi && s[i] > s[r.si]) r.si = i;
    r.bv = s[r.bi];
    r.sv = s[r.si];
    r.mg = r.bv - r.sv;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("best_idx", best_idx, e.bi);
        check("best_val", $signed(best_val), e.bv);
        check("second_idx", second_idx, e.si);
        check("second_val", $signed(second_val), e.sv);
        check("margin", margin, e.mg);
        check("done_latency", cyc, last_acc);
      end
    end
  end

  task automatic run_frame(input int s[NC], input bit gaps,
                           input bit hold);
    exp_q.push_back(model(s));
    frames++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_in_accum", busy, 1);
    check("ready_in_accum", in_ready, 1);
    check("stray_cleared", stray_err, 0);
    for (int i = 0; i < NC; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_data  = DW'(s[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    last_acc = cyc;
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_best_idx"}, best_idx, 0);
    check({tag, "_best_val"}, best_val, 0);
    check({tag, "_second_idx"}, second_idx, 0);
    check({tag, "_second_val"}, second_val, 0);
    check({tag, "_margin"}, margin, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_stray"}, stray_err, 0);
  endtask

  int f1[NC] = '{100, -50, 200, 500, 123, -300, 250, 4000, 50, 10};
  int f2[NC] = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
  int f3[NC] = '{7, 7, 3, 1, 2, 0, -1, 5, 6, 4};
  int f4[NC] = '{0, 0, 32767, 0, 0, 0, 0, 0, 0, -32768};
  int f5[NC] = '{-32768, -32768, 32767, -32768, -32768,
                 -32768, -32768, -32768, -32768, -32768};

  initial begin
    res_t r;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    r = model(f1);
    check("pin1_bi", r.bi, 7);
    check("pin1_bv", r.bv, 4000);
    check("pin1_si", r.si, 3);
    check("pin1_mg", r.mg, 3500);
    r = model(f2);
    check("pin2_bi", r.bi, 0);
    check("pin2_si", r.si, 1);
    check("pin2_mg", r.mg, 1);
    r = model(f3);
    check("pin3_si", r.si, 1);
    check("pin3_mg", r.mg, 0);
    r = model(f5);
    check("pin5_bi", r.bi, 2);
    check("pin5_mg", r.mg, 65535);

    run_frame(f1, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("hold_start_done_count", done_cnt, 1);
    check("hold_best_val", $signed(best_val), 4000);
    check("hold_margin", margin, 3500);
    start = 1'b0;

    run_frame(f2, 1'b0, 1'b0);
    run_frame(f3, 1'b0, 1'b0);
    run_frame(f4, 1'b0, 1'b0);
    run_frame(f5, 1'b0, 1'b0);
    run_frame(f1, 1'b1, 1'b0);
    run_frame(f3, 1'b1, 1'b0);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data  = DW'(f1[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(posedge clk); #1 reset = 1'b0;
    run_frame(f2, 1'b0, 1'b0);

    @(posedge clk); #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("stray_set", stray_err, 1);
    repeat (2) @(posedge clk);
    #1 check("stray_sticky", stray_err, 1);
    run_frame(f4, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    check("done_total", done_cnt, frames);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
